dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-side bus responder for the 16-bit single-cycle core: serves the core's mem_addr/mem_wd/mem_ctrl,
//  returns mem_rd. Decodes into a word-addressed data RAM and a small MMIO block (GPIO + compare timer).
//  Timer raises an interrupt line that top level wires into the core's irq[0].
// PARAMETERS
//  CPU_WIDTH   16  data/address width; decode uses bit CPU_WIDTH-1
//  RAM_AW      10  RAM address bits; depth = 2**RAM_AW words
//  GPIO_WIDTH  8   GPIO in/out width, <= CPU_WIDTH
// PORTS
//  clk        in   1           system clock, all state on rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  mem_addr   in   CPU_WIDTH   word address from core
//  mem_wd     in   CPU_WIDTH   write data from core
//  mem_ctrl   in   1           1 = write this cycle, 0 = read
//  mem_rd     out  CPU_WIDTH   read data, combinational from mem_addr
//  gpio_in    in   GPIO_WIDTH  async external inputs
//  gpio_out   out  GPIO_WIDTH  registered outputs
//  irq_timer  out  1           level interrupt = timer pending flag
// BEHAVIOUR
//  - Core is single-cycle: reads are zero-latency (mem_rd combinational), writes commit at the clk edge.
//  - Map: addr[15]=0 -> RAM[addr[RAM_AW-1:0]] (upper bits ignored, RAM aliases). addr[15]=1 -> MMIO:
//    0x8000 GPIO_OUT RW | 0x8001 GPIO_IN RO | 0x8002 TCNT RW | 0x8003 TCMP RW |
//    0x8004 TCTRL: b0 EN, b1 AUTO_RELOAD, b2 PEND (read; write 1 clears), other bits read 0.
//  - Unmapped MMIO: read 0, write ignored. Narrow regs zero-extend on read, truncate on write.
//  - RAM: no reset (sim init 0); write when mem_ctrl=1 && addr[15]=0.
//  - GPIO_IN: two-flop synchronizer; read returns 2nd stage (2-cycle latency to visibility).
//  - Timer per edge, EN=1: if TCNT==TCMP -> PEND<=1, TCNT <= AUTO_RELOAD ? 0 : TCNT+1; else TCNT<=TCNT+1.
//    TCNT wraps 0xFFFF->0x0000 without flag. EN=0: TCNT holds, no match detection.
//  - Simultaneous: core write to TCNT beats increment/reload; match-set of PEND beats write-1-clear;
//    write to TCTRL takes effect next edge (match uses old EN/TCMP this edge).
//  - Reset (any time, incl. mid-count): gpio_out=0, sync flops=0, TCNT=0, TCMP=0xFFFF, TCTRL=0,
//    irq_timer=0. mem_rd still reflects addr during reset (RAM contents preserved).
// CONFIGURATION
//  - DMEM_TIMER_EN defined: timer regs and irq_timer as above.
//  - Not defined: timer logic absent; 0x8002-0x8004 read 0, writes ignored, irq_timer tied 0.
// STRUCTURE
//  - para.v: MMIO address constants (ADDR_GPIO_OUT..ADDR_TCTRL), TCTRL bit indices, TCMP reset value.
//  - One sub-module dmem_timer (TCNT/TCMP/TCTRL, match, irq); instantiated only under DMEM_TIMER_EN.
//  - Top: address decode, RAM array, GPIO regs, read mux.
// TESTING
//  1 RAM: write 0x1234 @0x0005, read @0x0005 -> 0x1234; read @0x0405 (RAM_AW=10) -> 0x1234 alias.
//  2 GPIO: write 0x00A5 @0x8000 -> gpio_out=0xA5 after edge; gpio_in=0x3C -> read @0x8001 =0x003C
//    2 edges later, not before.
//  3 Timer one-shot: TCMP=5, TCTRL=0x1 -> irq_timer rises after 6th edge past the TCTRL write edge;
//    TCNT reads 6 next cycle; write 0x4 @0x8004 clears irq (EN also cleared).
//  4 Auto-reload: TCMP=3, TCTRL=0x3 -> PEND set every 4 edges, TCNT sequence 0,1,2,3,0; clear-write
//    on same edge as match -> PEND stays 1.
//  5 Unmapped/collision: write @0x8010 -> no state change, read 0; write TCNT=0x0100 while EN=1 ->
//    TCNT reads 0x0100 next cycle (no +1).
//  6 Reset mid-count: assert rst_n=0 asynchronously with TCNT=2 -> irq_timer,gpio_out,TCNT=0,
//    TCMP=0xFFFF immediately; RAM @0x0005 still 0x1234. Rerun 3 with DMEM_TIMER_EN undefined -> reads 0, irq 0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared constants and helpers for the data-side responder.
//   - MMIO register addresses (ADDR_GPIO_OUT .. ADDR_TCTRL)
//   - TCTRL bit indices and the TCMP reset value
//   - mmio_sel_e register select and the decode_mmio() helper
package dmem_responder_pkg;

    localparam logic [15:0] ADDR_GPIO_OUT = 16'h8000;
    localparam logic [15:0] ADDR_GPIO_IN  = 16'h8001;
    localparam logic [15:0] ADDR_TCNT     = 16'h8002;
    localparam logic [15:0] ADDR_TCMP     = 16'h8003;
    localparam logic [15:0] ADDR_TCTRL    = 16'h8004;

    localparam int unsigned TCTRL_EN_BIT   = 0;
    localparam int unsigned TCTRL_AUTO_BIT = 1;
    localparam int unsigned TCTRL_PEND_BIT = 2;

    localparam logic [15:0] TCMP_RESET = 16'hFFFF;

    typedef enum logic [2:0] {
        RegNone,
        RegGpioOut,
        RegGpioIn,
        RegTcnt,
        RegTcmp,
        RegTctrl
    } mmio_sel_e;

    // Full-address compare; anything else in the MMIO half is unmapped.
    function automatic mmio_sel_e decode_mmio(input logic [15:0] addr);
        case (addr)
            ADDR_GPIO_OUT: return RegGpioOut;
            ADDR_GPIO_IN:  return RegGpioIn;
            ADDR_TCNT:     return RegTcnt;
            ADDR_TCMP:     return RegTcmp;
            ADDR_TCTRL:    return RegTctrl;
            default:       return RegNone;
        endcase
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// dmem_timer: compare timer behind the MMIO block.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   wdata_i         core write data
//   tcnt_we_i       write strobe for TCNT
//   tcmp_we_i       write strobe for TCMP
//   tctrl_we_i      write strobe for TCTRL (EN, AUTO_RELOAD, PEND write-1-clear)
//   tcnt_o, tcmp_o  current counter / compare values
//   tctrl_o         {PEND, AUTO_RELOAD, EN}
//   irq_o           level interrupt, equal to PEND
module dmem_timer
    import dmem_responder_pkg::*;
#(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] wdata_i,
    input  logic             tcnt_we_i,
    input  logic             tcmp_we_i,
    input  logic             tctrl_we_i,
    output logic [Width-1:0] tcnt_o,
    output logic [Width-1:0] tcmp_o,
    output logic [2:0]       tctrl_o,
    output logic             irq_o
);

    logic [Width-1:0] tcnt_q, tcnt_d;
    logic [Width-1:0] tcmp_q, tcmp_d;
    logic             en_q, en_d;
    logic             auto_q, auto_d;
    logic             pend_q, pend_d;
    logic             match;

    always_comb begin
        // Match is judged on the registered EN/TCMP, so TCTRL/TCMP writes act next edge.
        match = en_q && (tcnt_q == tcmp_q);

        tcnt_d = tcnt_q;
        if (tcnt_we_i) begin
            tcnt_d = wdata_i;
        end else if (en_q) begin
            tcnt_d = (match && auto_q) ? '0 : tcnt_q + Width'(1);
        end

        tcmp_d = tcmp_we_i ? wdata_i : tcmp_q;
        en_d   = tctrl_we_i ? wdata_i[TCTRL_EN_BIT] : en_q;
        auto_d = tctrl_we_i ? wdata_i[TCTRL_AUTO_BIT] : auto_q;

        // A match on the same edge wins over a write-1-clear.
        pend_d = pend_q;
        if (tctrl_we_i && wdata_i[TCTRL_PEND_BIT]) begin
            pend_d = 1'b0;
        end
        if (match) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_q <= '0;
            tcmp_q <= Width'(TCMP_RESET);
            en_q   <= 1'b0;
            auto_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tcmp_q <= tcmp_d;
            en_q   <= en_d;
            auto_q <= auto_d;
            pend_q <= pend_d;
        end
    end

    assign tcnt_o  = tcnt_q;
    assign tcmp_o  = tcmp_q;
    assign tctrl_o = {pend_q, auto_q, en_q};
    assign irq_o   = pend_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-side bus responder for the 16-bit single-cycle core.
// Reads are combinational from mem_addr; writes commit on the rising clk edge.
// Map: addr[CPU_WIDTH-1]=0 -> word RAM (aliased on the low RAM_AW bits),
//      addr[CPU_WIDTH-1]=1 -> MMIO (GPIO_OUT, GPIO_IN, TCNT, TCMP, TCTRL).
//   clk, rst_n   clock, asynchronous active-low reset (RAM is not reset)
//   mem_addr     word address from core
//   mem_wd       write data from core
//   mem_ctrl     1 = write this cycle
//   mem_rd       read data
//   gpio_in      asynchronous external inputs (two-flop synchronised)
//   gpio_out     registered outputs
//   irq_timer    timer pending flag
// Build option: define DMEM_TIMER_EN to include the compare timer; without it the
// timer addresses read 0, ignore writes, and irq_timer is tied low.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned CPU_WIDTH  = 16,
    parameter int unsigned RAM_AW     = 10,
    parameter int unsigned GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CPU_WIDTH-1:0]  mem_addr,
    input  logic [CPU_WIDTH-1:0]  mem_wd,
    input  logic                  mem_ctrl,
    output logic [CPU_WIDTH-1:0]  mem_rd,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  irq_timer
);

    localparam int unsigned RamDepth = 2 ** RAM_AW;

    logic                  is_mmio;
    mmio_sel_e             sel;
    logic [RAM_AW-1:0]     ram_idx;
    logic                  ram_we;
    logic [CPU_WIDTH-1:0]  ram_q [RamDepth];

    logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_WIDTH-1:0] gpio_sync1_q, gpio_sync2_q;

    assign is_mmio = mem_addr[CPU_WIDTH-1];
    assign sel     = decode_mmio(16'(mem_addr));
    assign ram_idx = mem_addr[RAM_AW-1:0];
    assign ram_we  = mem_ctrl && !is_mmio;

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= mem_wd;
        end
    end

    always_comb begin
        gpio_out_d = gpio_out_q;
        if (mem_ctrl && sel == RegGpioOut) begin
            gpio_out_d = mem_wd[GPIO_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out_q   <= '0;
            gpio_sync1_q <= '0;
            gpio_sync2_q <= '0;
        end else begin
            gpio_out_q   <= gpio_out_d;
            gpio_sync1_q <= gpio_in;
            gpio_sync2_q <= gpio_sync1_q;
        end
    end

    assign gpio_out = gpio_out_q;

`ifdef DMEM_TIMER_EN
    logic [CPU_WIDTH-1:0] tcnt, tcmp;
    logic [2:0]           tctrl;

    dmem_timer #(
        .Width (CPU_WIDTH)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wdata_i    (mem_wd),
        .tcnt_we_i  (mem_ctrl && sel == RegTcnt),
        .tcmp_we_i  (mem_ctrl && sel == RegTcmp),
        .tctrl_we_i (mem_ctrl && sel == RegTctrl),
        .tcnt_o     (tcnt),
        .tcmp_o     (tcmp),
        .tctrl_o    (tctrl),
        .irq_o      (irq_timer)
    );
`else
    assign irq_timer = 1'b0;
`endif

    always_comb begin
        mem_rd = '0;
        if (!is_mmio) begin
            mem_rd = ram_q[ram_idx];
        end else begin
            case (sel)
                RegGpioOut: mem_rd = CPU_WIDTH'(gpio_out_q);
                RegGpioIn:  mem_rd = CPU_WIDTH'(gpio_sync2_q);
`ifdef DMEM_TIMER_EN
                RegTcnt:    mem_rd = tcnt;
                RegTcmp:    mem_rd = tcmp;
                RegTctrl:   mem_rd = CPU_WIDTH'(tctrl);
`endif
                default:    mem_rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Expected values come from a RAM array
// model, remembered GPIO values and edge-count arithmetic for the timer.
// Timer expectations follow the DMEM_TIMER_EN build option.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic [15:0] mem_wd;
    logic        mem_ctrl;
    logic [15:0] mem_rd;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        irq_timer;

    int unsigned checks = 0;
    int unsigned passes = 0;

    logic [15:0] ram_model [1024];
    int unsigned written [$];

    dmem_responder #(
        .CPU_WIDTH  (16),
        .RAM_AW     (10),
        .GPIO_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_ctrl  (mem_ctrl),
        .mem_rd    (mem_rd),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .irq_timer (irq_timer)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        mem_addr = addr;
        mem_wd   = data;
        mem_ctrl = 1'b1;
        @(posedge clk);
        #1;
        mem_ctrl = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, output logic [15:0] data);
        mem_addr = addr;
        mem_ctrl = 1'b0;
        #1;
        data = mem_rd;
    endtask

    // Edges until irq_timer rises, bounded.
    task automatic edges_to_irq(input int bound, output int n);
        n = 0;
        while (!irq_timer && n < bound) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] a;
        logic [7:0]  g;
        int          n;
        int unsigned c;
        int unsigned idx;
        bit          timer_on;

`ifdef DMEM_TIMER_EN
        timer_on = 1'b1;
`else
        timer_on = 1'b0;
`endif

        // Reset state, checked while reset is held.
        rst_n = 1'b1; mem_addr = '0; mem_wd = '0; mem_ctrl = 1'b0; gpio_in = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_gpio_out", gpio_out, 0);
        check("rst_irq", irq_timer, 0);
        rd(16'h8002, v); check("rst_tcnt", v, 0);
        rd(16'h8003, v); check("rst_tcmp", v, timer_on ? 16'hFFFF : 16'h0000);
        rd(16'h8004, v); check("rst_tctrl", v, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // RAM directed write and alias.
        wr(16'h0005, 16'h1234);
        rd(16'h0005, v); check("ram_5", v, 16'h1234);
        rd(16'h0405, v); check("ram_alias_405", v, 16'h1234);

        // RAM random writes, read back through random aliases.
        for (int i = 0; i < 24; i++) begin
            idx = $urandom_range(0, 1023);
            v = 16'($urandom);
            a = {1'b0, 5'($urandom), 10'(idx)};
            wr(a, v);
            ram_model[idx] = v;
            written.push_back(idx);
        end
        for (int i = 0; i < 16; i++) begin
            idx = written[$urandom_range(0, written.size() - 1)];
            a = {1'b0, 5'($urandom), 10'(idx)};
            rd(a, v); check("ram_rand", v, ram_model[idx]);
        end

        // GPIO out, including truncation of the upper write bits.
        wr(16'h8000, 16'h00A5);
        check("gpio_out_a5", gpio_out, 8'hA5);
        rd(16'h8000, v); check("gpio_out_rd", v, 16'h00A5);
        wr(16'h8000, 16'hFF5A);
        check("gpio_out_trunc", gpio_out, 8'h5A);

        // GPIO in: visible after exactly two edges.
        gpio_in = 8'h3C;
        rd(16'h8001, v); check("gpio_in_0edge", v, 0);
        tick(1);
        rd(16'h8001, v); check("gpio_in_1edge", v, 0);
        tick(1);
        rd(16'h8001, v); check("gpio_in_2edge", v, 16'h003C);
        for (int i = 0; i < 4; i++) begin
            g = 8'($urandom);
            if (g == gpio_in) g = ~g;
            v = {8'h00, gpio_in};
            gpio_in = g;
            tick(1);
            rd(16'h8001, a); check("gpio_in_rand_old", a, v);
            tick(1);
            rd(16'h8001, a); check("gpio_in_rand_new", a, {8'h00, g});
            g = 8'($urandom);
            wr(16'h8000, {8'($urandom), g});
            check("gpio_out_rand", gpio_out, g);
        end

        // Unmapped MMIO.
        g = gpio_out;
        wr(16'h8010, 16'hBEEF);
        rd(16'h8010, v); check("unmapped_rd", v, 0);
        rd(16'h8005, v); check("unmapped_8005", v, 0);
        check("unmapped_gpio", gpio_out, g);
        rd(16'h8002, v); check("unmapped_tcnt", v, 0);

        if (timer_on) begin
            // One-shot, TCMP=5: PEND after 6 edges past the TCTRL write edge.
            wr(16'h8003, 16'd5);
            wr(16'h8004, 16'h0001);
            tick(5);
            check("oneshot_5edges_irq", irq_timer, 0);
            tick(1);
            check("oneshot_6edges_irq", irq_timer, 1);
            rd(16'h8002, v); check("oneshot_tcnt6", v, 6);
            wr(16'h8004, 16'h0004);
            check("oneshot_clear_irq", irq_timer, 0);
            rd(16'h8004, v); check("oneshot_tctrl", v, 0);
            tick(3);
            rd(16'h8002, v); check("oneshot_hold", v, 7);

            // Random one-shot compares.
            for (int i = 0; i < 3; i++) begin
                c = $urandom_range(2, 20);
                wr(16'h8002, 16'h0000);
                wr(16'h8003, 16'(c));
                wr(16'h8004, 16'h0001);
                edges_to_irq(c + 10, n);
                check("oneshot_rand_edges", n, c + 1);
                rd(16'h8002, v); check("oneshot_rand_tcnt", v, c + 1);
                wr(16'h8004, 16'h0004);
                check("oneshot_rand_clear", irq_timer, 0);
            end

            // Auto-reload, TCMP=3: TCNT 1,2,3,0,... and PEND from edge 4.
            wr(16'h8002, 16'h0000);
            wr(16'h8003, 16'd3);
            wr(16'h8004, 16'h0003);
            for (int k = 1; k <= 8; k++) begin
                tick(1);
                rd(16'h8002, v); check("auto_tcnt", v, k % 4);
                check("auto_irq", irq_timer, k >= 4);
            end
            // Clear-write on the match edge: match wins.
            tick(3);
            rd(16'h8002, v); check("auto_pre_match", v, 3);
            wr(16'h8004, 16'h0007);
            check("auto_clear_on_match", irq_timer, 1);
            rd(16'h8002, v); check("auto_reload0", v, 0);
            wr(16'h8004, 16'h0007);
            check("auto_clear_ok", irq_timer, 0);
            rd(16'h8002, v); check("auto_after_clear", v, 1);
            rd(16'h8004, v); check("auto_tctrl", v, 3);

            // Random auto-reload periods.
            for (int i = 0; i < 3; i++) begin
                c = $urandom_range(2, 12);
                wr(16'h8004, 16'h0004);
                wr(16'h8002, 16'h0000);
                wr(16'h8003, 16'(c));
                wr(16'h8004, 16'h0003);
                edges_to_irq(c + 10, n);
                check("auto_rand_first", n, c + 1);
                wr(16'h8004, 16'h0007);
                check("auto_rand_clear", irq_timer, 0);
                edges_to_irq(c + 10, n);
                check("auto_rand_period", n, c);
            end

            // Core write to TCNT beats increment.
            wr(16'h8002, 16'h0100);
            rd(16'h8002, v); check("collide_tcnt", v, 16'h0100);
            tick(1);
            rd(16'h8002, v); check("collide_next", v, 16'h0101);

            // Wrap without flag.
            wr(16'h8004, 16'h0004);
            wr(16'h8003, 16'h0010);
            wr(16'h8002, 16'hFFFE);
            wr(16'h8004, 16'h0001);
            tick(1);
            rd(16'h8002, v); check("wrap_ffff", v, 16'hFFFF);
            tick(1);
            rd(16'h8002, v); check("wrap_0000", v, 0);
            check("wrap_no_irq", irq_timer, 0);

            // Reset mid-count with PEND set and TCNT=2.
            wr(16'h8004, 16'h0004);
            wr(16'h8002, 16'h0000);
            wr(16'h8003, 16'd3);
            wr(16'h8004, 16'h0003);
            tick(4);
            check("pre_rst_irq", irq_timer, 1);
            tick(2);
            rd(16'h8002, v); check("pre_rst_tcnt", v, 2);
        end else begin
            // Timer absent: registers read 0, irq stays low.
            wr(16'h8003, 16'd5);
            wr(16'h8004, 16'h0001);
            tick(8);
            check("notimer_irq", irq_timer, 0);
            rd(16'h8002, v); check("notimer_tcnt", v, 0);
            rd(16'h8003, v); check("notimer_tcmp", v, 0);
            rd(16'h8004, v); check("notimer_tctrl", v, 0);
        end

        // Asynchronous reset away from the clock edge.
        wr(16'h0005, 16'h1234);
        wr(16'h8000, 16'h00C3);
        gpio_in = 8'h99;
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_irq", irq_timer, 0);
        check("arst_gpio_out", gpio_out, 0);
        rd(16'h8001, v); check("arst_sync", v, 0);
        rd(16'h8002, v); check("arst_tcnt", v, 0);
        rd(16'h8003, v); check("arst_tcmp", v, timer_on ? 16'hFFFF : 16'h0000);
        rd(16'h8004, v); check("arst_tctrl", v, 0);
        rd(16'h0005, v); check("arst_ram", v, 16'h1234);
        #1 rst_n = 1'b1;
        tick(3);
        rd(16'h8002, v); check("post_rst_tcnt_idle", v, 0);
        check("post_rst_irq", irq_timer, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
